// File: rtl/ascon_pack.sv
// Shared types and constant tables for the ASCON permutation datapath.
package ascon_pack;

    // S[0] = x0 ... S[4] = x4, each a 64-bit lane.
    typedef logic [0:4][63:0] type_state;

    // Round constants. Entries 12..15 are zero so any 4-bit round index is safe.
    localparam logic [7:0] RC [16] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87,
        8'h78, 8'h69, 8'h5A, 8'h4B, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };

    // Linear-layer rotation amounts per lane.
    localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

endpackage

// File: rtl/ascon_permutation_sbox.sv
// 5-bit ASCON S-box applied to one bit column; x0 is the MSB of the word.
module sbox
    import ascon_pack::*;
(
    input  logic [4:0] x_i,
    output logic [4:0] y_o
);

    assign y_o = SBOX[x_i];

endmodule

// File: rtl/ascon_permutation.sv
// One ASCON round (pC, pS, pL) per clock on a registered 320-bit state.
module ascon_permutation
    import ascon_pack::*;
(
    input  logic        clock_i,
    input  logic        rst_i,
    input  type_state   S_i,
    input  logic [3:0]  round_i,
    input  logic        init_state_i,
    output type_state   S_o
);

    type_state  s_q, s_d;
    type_state  x_in, x_c, x_s, x_l;
    logic [4:0] col_in  [64];
    logic [4:0] col_out [64];

    // Constant addition on the selected round input.
    always_comb begin
        x_in = init_state_i ? S_i : s_q;
        x_c = x_in;
        x_c[2][7:0] = x_in[2][7:0] ^ RC[round_i];
    end

    // Substitution: one S-box per bit column, results scattered back to lanes.
    for (genvar j = 0; j < 64; j++) begin : g_col
        assign col_in[j] = {x_c[0][j], x_c[1][j], x_c[2][j], x_c[3][j], x_c[4][j]};

        sbox u_sbox (
            .x_i (col_in[j]),
            .y_o (col_out[j])
        );

        for (genvar i = 0; i < 5; i++) begin : g_lane
            assign x_s[i][j] = col_out[j][4-i];
        end
    end

    always_comb begin
        x_l = '0;
        for (int i = 0; i < 5; i++) begin
            x_l[i] = x_s[i] ^ rotr(x_s[i], ROT_A[i]) ^ rotr(x_s[i], ROT_B[i]);
        end
        s_d = x_l;
    end

    always_ff @(posedge clock_i) begin
        if (rst_i) s_q <= '0;
        else       s_q <= s_d;
    end

    assign S_o = s_q;

endmodule

// File: tb/tb_ascon_permutation.sv
// Directed bench for ascon_permutation with a bitsliced reference round.
module tb_ascon_permutation;
    import ascon_pack::*;

    logic       clk = 1'b0;
    logic       rst;
    type_state  s_in;
    logic [3:0] rnd;
    logic       init;
    type_state  s_out;

    int checks = 0;
    int errors = 0;

    ascon_permutation dut (
        .clock_i      (clk),
        .rst_i        (rst),
        .S_i          (s_in),
        .round_i      (rnd),
        .init_state_i (init),
        .S_o          (s_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag, input type_state got, input type_state exp);
        for (int i = 0; i < 5; i++) chk($sformatf("%s_x%0d", tag, i), got[i], exp[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Reference round in the bitsliced boolean form, independent of the lookup table.
    function automatic type_state ref_round(input type_state s, input int r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        type_state o;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        if (r < 12) x2 ^= 64'(((15 - r) << 4) | r);
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        o[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        o[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return o;
    endfunction

    function automatic type_state ref_rounds(input type_state s, input int first, input int last);
        type_state t;
        t = s;
        for (int r = first; r <= last; r++) t = ref_round(t, r);
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        type_state a, b, exp, zero;
        logic [7:0] rc_hand [12];
        rc_hand = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
        zero = '0;
        a = {64'h00001000808C0001, 64'h6CB10AD9CA912F80, 64'h691AED630E81901F,
             64'h0C4C36A20853217C, 64'h46487B3E06D9D7A8};
        b = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hA5A5A5A55A5A5A5A,
             64'hDEADBEEFCAFEF00D, 64'h0F1E2D3C4B5A6978};

        // Reset clears the state regardless of S_i or init.
        rst = 1'b1; init = 1'b0; rnd = 4'd3; s_in = b;
        tick();
        chk_state("rst", s_out, zero);
        init = 1'b1;
        tick();
        chk_state("rst_init", s_out, zero);

        // Single round 0 from the zero state, hand-derived lanes.
        rst = 1'b0; init = 1'b1; rnd = 4'd0; s_in = '0;
        tick();
        chk("r0_x0", s_out[0], 64'h001E0F00000000F0);
        chk("r0_x1", s_out[1], 64'h00000001E0000770);
        chk("r0_x2", s_out[2], 64'h3FFFFFFFFFFFFF74);
        chk("r0_x3", s_out[3], 64'h3C780000000000F0);
        chk("r0_x4", s_out[4], 64'h0000000000000000);

        // From zero, x0 low byte equals the round constant (rotated copies land above bit 35).
        for (int r = 0; r < 12; r++) begin
            rnd = 4'(r);
            tick();
            chk($sformatf("rc%0d", r), {56'h0, s_out[0][7:0]}, {56'h0, rc_hand[r]});
        end
        rnd = 4'd12;
        tick();
        chk("rc12_x0", s_out[0], 64'h0);
        chk("rc12_x2", s_out[2], 64'hFFFFFFFFFFFFFFFF);

        // Full p12 from the load cycle.
        init = 1'b1; rnd = 4'd0; s_in = a;
        tick();
        init = 1'b0; s_in = b;
        for (int r = 1; r < 12; r++) begin
            rnd = 4'(r);
            tick();
        end
        exp = ref_rounds(a, 0, 11);
        chk_state("p12", s_out, exp);

        // Reload at round 5 discards the running state.
        init = 1'b1; rnd = 4'd0; s_in = a;
        tick();
        init = 1'b0;
        for (int r = 1; r < 5; r++) begin
            rnd = 4'(r);
            tick();
        end
        init = 1'b1; rnd = 4'd5; s_in = b;
        tick();
        init = 1'b0; s_in = a;
        for (int r = 6; r < 12; r++) begin
            rnd = 4'(r);
            tick();
        end
        exp = ref_rounds(b, 5, 11);
        chk_state("reload", s_out, exp);

        // Reset at round 7 zeroes the state; permutation continues from zero.
        init = 1'b1; rnd = 4'd0; s_in = a;
        tick();
        init = 1'b0;
        for (int r = 1; r < 7; r++) begin
            rnd = 4'(r);
            tick();
        end
        rst = 1'b1; rnd = 4'd7;
        tick();
        chk_state("midrst", s_out, zero);
        rst = 1'b0;
        for (int r = 8; r < 12; r++) begin
            rnd = 4'(r);
            tick();
        end
        exp = ref_rounds(zero, 8, 11);
        chk_state("postrst", s_out, exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
